nonce_verifier: RTL
===================

# nonce_verifier

Independent proof-of-work checker at the receiving end of the mining datapath. It accepts one 12-byte block header, one candidate 32-bit nonce and an 8-bit target, and recomputes the 24-bit micro-hash iteratively. It then reports whether the nonce satisfies the target. Typical uses are auditing `finished`/`nonce_out` results from the parallel miner and validating nonces supplied from outside the chip.

## Interface
- `byte`, default 8: byte width; the header is `byte*12` bits, the hash block `byte*16`, the hash `byte*3`.
- `clk` input, 1 bit: single clock; all logic is rising-edge.
- `reset` input, 1 bit: synchronous, active-high. Registers clear on the clock edge where it is high.
- `valid_in` input, 1 bit: a request is present this cycle.
- `ready_out` output, 1 bit: the block can accept a request this cycle.
- `data_in` input, `byte*12` bits: block header.
- `nonce_in` input, 32 bits: candidate nonce.
- `target` input, 8 bits: difficulty threshold.
- `busy` output, 1 bit: a check is in progress.
- `done` output, 1 bit: one-cycle pulse; `pass` and `h_out` are valid.
- `pass` output, 1 bit: nonce meets target.
- `h_out` output, `byte*3` bits: recomputed hash.

## Operation
- Request acceptance:
  - A request is accepted on the rising edge where `valid_in && ready_out`.
  - On acceptance, `data_in`, `nonce_in` and `target` are captured into internal registers. Later changes to these inputs have no effect on the accepted request.
- Hash block assembly, using the miner's concatenation order:
  - `W[0..11]` = `data_in` bytes, most-significant byte first.
  - `W[12..15]` = `nonce_in` bytes, most-significant byte first.
- Hash computation:
  - One round per cycle, 32 rounds (i = 0..31).
  - Message expansion runs on the fly over a 16-byte shifting window: `W[i] = W[i-3] | (W[i-9] ^ W[i-14])` for i ≥ 16.
  - The round function, round constants and initial H value come from the shared package. Results must be bit-exact with the miner's hash cores.
  - A final add step produces `h_out`.
- Pass rule: `pass = (h[23:16] < target) && (h[15:8] < target)`, as an unsigned 8-bit compare. This is the same rule the miner's comparators use.
- State machine:
  - IDLE: `ready_out`=1. On accept, go to ROUND and set round counter to 0.
  - ROUND: counter increments each cycle. When counter=31, go to FINAL.
  - FINAL: apply the final add and evaluate the pass rule, then go to DONE.
  - DONE: `done`=1 and `ready_out`=1. A new accept in this cycle goes to ROUND; otherwise go to IDLE.
- `valid_in` while `busy` is ignored: no capture and no error indication. Upstream must hold `valid_in` until it sees `ready_out`.
- `pass` and `h_out` hold their value after `done` until the FINAL state of the next request.

## Timing
- Reset values:
  - `ready_out`=1, `busy`=0, `done`=0, `pass`=0, `h_out`=0.
  - Round counter=0, state=IDLE.
- Cycle-level sequence, with accept at edge E0:
  - `busy` is high from E0 to E33.
  - Rounds execute on E1..E32.
  - FINAL is registered at E33.
  - `done`, `pass` and `h_out` are valid after E33 for one cycle.
- Latency is 34 cycles from accept to `done`. Throughput is one check per 34 cycles, because back-to-back accepts are allowed in the DONE cycle.
- Boundary conditions:
  - Round counter wrap: the counter is 5 bits and leaves ROUND exactly at 31; it never wraps into round 0 while in ROUND.
  - `target`=0x00 always gives `pass`=0.
  - `target`=0xFF gives `pass`=0 only if a compared byte equals 0xFF.
  - Reset mid-check aborts it: no `done` pulse, all outputs return to their reset values at that edge.
  - `valid_in` coincident with `reset`: reset wins and the request is not accepted.

## Structure
- Shared package `micro_hash_pkg`:
  - initial H value and round constants;
  - round function `hash_round`, expansion function `hash_expand` and final-add function;
  - `HASH_ROUNDS`=32.
  - The miner cores must use the same package.
- One sub-module, `micro_hash_iter`, is natural. It is the sequential one-round-per-cycle hash engine with start and done handshake.
- `nonce_verifier` wraps `micro_hash_iter` with the request capture, the pass compare and the handshake state machine.

## Test plan
1. Reset, then idle 5 cycles → `ready_out`=1; `busy`, `done`, `pass` are 0; `h_out`=0.
2. Header, nonce and target taken from a miner run where `finished` asserted → `done` 34 cycles after accept, `pass`=1, `h_out` equal to the golden-model hash.
3. Same header and nonce with `target`=0x00 → `pass`=0, and `h_out` identical to scenario 2.
4. Two requests back-to-back, the second accepted in the first request's DONE cycle → two `done` pulses 34 cycles apart, each with the correct `h_out`.
5. `data_in` and `nonce_in` changed every cycle while `busy`, with `valid_in` held high → `h_out` reflects only the values captured at accept.
6. `reset` asserted at round 17 → no `done` pulse, outputs at reset values; a fresh request afterwards completes correctly.

Source files
------------

// File: rtl/micro_hash_pkg.sv
// Shared micro-hash definition used by both the miner cores and the nonce verifier.
// Everything that affects hash bit-exactness lives here.
package micro_hash_pkg;

  localparam int BYTE_W      = 8;
  localparam int HASH_ROUNDS = 32;
  localparam int BLOCK_BYTES = 16;
  localparam int HDR_BYTES   = 12;

  typedef logic [BYTE_W-1:0]   hbyte_t;
  typedef logic [3*BYTE_W-1:0] hash_t;

  localparam hash_t H_INIT = 24'h6A09E6;

  function automatic hbyte_t round_const(input logic [4:0] idx);
    return hbyte_t'(8'h5B + {3'b000, idx} * 8'h3D);
  endfunction

  // State is three bytes {a, b, c}; each round mixes one message byte into a.
  function automatic hash_t hash_round(input hash_t h, input hbyte_t w, input hbyte_t k);
    hbyte_t a, b, c, a_n, b_n, c_n;
    a   = h[23:16];
    b   = h[15:8];
    c   = h[7:0];
    a_n = (a ^ w) + {c[5:0], c[7:6]} + k;
    b_n = {a[4:0], a[7:5]} ^ c;
    c_n = b + (c ^ k);
    return {a_n, b_n, c_n};
  endfunction

  function automatic hbyte_t hash_expand(input hbyte_t w_m3, input hbyte_t w_m9,
                                         input hbyte_t w_m14);
    return w_m3 | (w_m9 ^ w_m14);
  endfunction

  function automatic hash_t hash_final(input hash_t h);
    return h + H_INIT;
  endfunction

  function automatic logic pass_check(input hash_t h, input hbyte_t tgt);
    return (h[23:16] < tgt) && (h[15:8] < tgt);
  endfunction

endpackage

// File: rtl/micro_hash_iter.sv
// Iterative micro-hash engine: loads a 16-byte block on start, runs one round per
// clock and pulses done once the last round has been applied to h.
module micro_hash_iter
  import micro_hash_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [BLOCK_BYTES*BYTE_W-1:0] block,
  output logic                          done,
  output logic [4:0]                    round_idx,
  output hash_t                         h
);

  hbyte_t win [BLOCK_BYTES];
  logic   running;

  // win[0] is W[i] for the current round; the new tail is W[i+16].
  always_ff @(posedge clk) begin
    if (reset) begin
      running   <= 1'b0;
      done      <= 1'b0;
      round_idx <= '0;
      h         <= '0;
      for (int j = 0; j < BLOCK_BYTES; j++) win[j] <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        running   <= 1'b1;
        round_idx <= '0;
        h         <= H_INIT;
        for (int j = 0; j < BLOCK_BYTES; j++)
          win[j] <= block[(BLOCK_BYTES-1-j)*BYTE_W +: BYTE_W];
      end else if (running) begin
        h <= hash_round(h, win[0], round_const(round_idx));
        for (int j = 0; j < BLOCK_BYTES-1; j++) win[j] <= win[j+1];
        win[BLOCK_BYTES-1] <= hash_expand(win[13], win[7], win[2]);
        if (round_idx == 5'(HASH_ROUNDS-1)) begin
          running <= 1'b0;
          done    <= 1'b1;
        end else begin
          round_idx <= round_idx + 5'd1;
        end
      end
    end
  end

endmodule

// File: rtl/nonce_verifier.sv
// Proof-of-work checker: captures a header/nonce/target request, recomputes the
// micro-hash and reports whether the nonce meets the target.
module nonce_verifier
  import micro_hash_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        valid_in,
  output logic                        ready_out,
  input  logic [HDR_BYTES*BYTE_W-1:0] data_in,
  input  logic [31:0]                 nonce_in,
  input  logic [7:0]                  target,
  output logic                        busy,
  output logic                        done,
  output logic                        pass,
  output logic [3*BYTE_W-1:0]         h_out
);

  // state   | meaning
  // S_IDLE  | waiting for a request
  // S_ROUND | engine running rounds 0..31
  // S_FINAL | final add and target compare
  // S_DONE  | result pulse; may accept the next request
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ROUND = 2'd1;
  localparam logic [1:0] S_FINAL = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0] state;
  hbyte_t     target_q;
  logic       accept;
  logic       eng_done;
  logic [4:0] round_idx;
  hash_t      eng_h;
  hash_t      final_h;

  assign ready_out = (state == S_IDLE) || (state == S_DONE);
  assign busy      = (state == S_ROUND) || (state == S_FINAL);
  assign done      = (state == S_DONE);
  assign accept    = valid_in && ready_out;
  assign final_h   = hash_final(eng_h);

  micro_hash_iter u_hash (
    .clk       (clk),
    .reset     (reset),
    .start     (accept),
    .block     ({data_in, nonce_in}),
    .done      (eng_done),
    .round_idx (round_idx),
    .h         (eng_h)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      target_q <= '0;
      pass     <= 1'b0;
      h_out    <= '0;
    end else begin
      if (accept) target_q <= target;
      case (state)
        S_IDLE:  if (accept) state <= S_ROUND;
        S_ROUND: if (round_idx == 5'(HASH_ROUNDS-1)) state <= S_FINAL;
        S_FINAL: begin
          if (eng_done) begin
            h_out <= final_h;
            pass  <= pass_check(final_h, target_q);
            state <= S_DONE;
          end
        end
        S_DONE:  state <= accept ? S_ROUND : S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
